// File: rtl/ad9361_tx_pkg.sv
// Shared types for the AD9361 TX feeder: sample/beat layout and FSM states.
package ad9361_tx_pkg;

   localparam int unsigned SAMPLE_W = 12;

   // One complex sample; i occupies the low bits.
   typedef struct packed {
      logic [SAMPLE_W-1:0] q;
      logic [SAMPLE_W-1:0] i;
   } iq_sample_t;

   // Two-channel beat; ch0 in the low half, matching the s_data layout.
   typedef struct packed {
      iq_sample_t ch1;
      iq_sample_t ch0;
   } tx_beat_t;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN,
      UNDERRUN
   } txfeed_state_e;

endpackage

// File: rtl/txfeed_fifo.sv
// Synchronous FIFO of tx_beat_t with flush; head is presented combinationally.
module txfeed_fifo
   import ad9361_tx_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned LW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          wr_en,
   input  tx_beat_t      wr_data,
   input  logic          rd_en,
   output tx_beat_t      rd_data,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   tx_beat_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_wr, do_rd;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_wr   = wr_en && !full && !flush;
   assign do_rd   = rd_en && !empty && !flush;
   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;

   // Pointer and occupancy update; flush wins over any access.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   // Pointer/level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage; contents need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/ad9361_tx_feeder.sv
// Buffers I/Q beats and releases one per sample strobe to the ad9361_if DAC ports.
// Optional ramp test pattern enabled by defining TXFEED_TESTPAT_EN (adds test_mode).
module ad9361_tx_feeder
   import ad9361_tx_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned RATE_DIV    = 4,
   parameter int unsigned PRIME_LEVEL = 8,
   localparam int unsigned LW = $clog2(DEPTH) + 1,
   localparam int unsigned DW = $clog2(RATE_DIV)
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic                enable,
`ifdef TXFEED_TESTPAT_EN
   input  logic                test_mode,
`endif
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [47:0]         s_data,
   output logic [SAMPLE_W-1:0] dac_data0_i,
   output logic [SAMPLE_W-1:0] dac_data0_q,
   output logic [SAMPLE_W-1:0] dac_data1_i,
   output logic [SAMPLE_W-1:0] dac_data1_q,
   output logic                sample_strobe,
   output logic                running,
   output logic [15:0]         underrun_cnt,
   output logic [LW-1:0]       fifo_level
);

   txfeed_state_e state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   tx_beat_t      dac_q, dac_d;
   logic [15:0]   ucnt_q, ucnt_d;
   tx_beat_t      fifo_head, ramp_beat;
   logic          fifo_full, fifo_empty;
   logic          strobe, flush, pop, underrun, prime_ok, tp_active;

   txfeed_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk     (sys_clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .wr_en   (s_valid && s_ready),
      .wr_data (tx_beat_t'(s_data)),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

`ifdef TXFEED_TESTPAT_EN
   logic [SAMPLE_W-1:0] ramp_q, ramp_d;

   assign tp_active = (state_q == RUN) && test_mode;
   assign ramp_beat = '{ch1: '{q: ~ramp_q, i: ramp_q}, ch0: '{q: ~ramp_q, i: ramp_q}};

   // Ramp advances once per strobe while the pattern is being emitted.
   always_comb begin
      ramp_d = ramp_q;
      if (tp_active && strobe) ramp_d = ramp_q + 1'b1;
   end

   // Ramp register.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) ramp_q <= '0;
      else        ramp_q <= ramp_d;
   end
`else
   assign tp_active = 1'b0;
   assign ramp_beat = '0;
`endif

   // Sample-rate divider; parked at zero while disabled.
   always_comb begin
      div_d = '0;
      if (enable) div_d = (div_q == DW'(RATE_DIV - 1)) ? '0 : div_q + 1'b1;
   end

   assign strobe = enable && (div_q == DW'(RATE_DIV - 1));

   // FSM outputs and per-cycle control decodes.
   always_comb begin
      flush         = (state_q != IDLE) && !enable;
      s_ready       = !fifo_full && !flush;
      running       = (state_q == RUN);
      sample_strobe = strobe;
      prime_ok      = (fifo_level >= LW'(PRIME_LEVEL));
      pop           = running && strobe && !tp_active && !fifo_empty;
      underrun      = running && strobe && !tp_active && fifo_empty;
   end

   // FSM next state; a disable in any active state flushes back to IDLE.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:            if (enable) state_d = PRIME;
            PRIME, UNDERRUN: if (prime_ok) state_d = RUN;
            RUN:             if (underrun) state_d = UNDERRUN;
            default:         state_d = IDLE;
         endcase
      end
   end

   // DAC data: zero outside RUN, load on strobe, otherwise hold the last sample.
   always_comb begin
      dac_d = dac_q;
      if (flush || (state_q != RUN)) begin
         dac_d = '0;
      end else if (strobe) begin
         if (tp_active)        dac_d = ramp_beat;
         else if (!fifo_empty) dac_d = fifo_head;
         else                  dac_d = '0;
      end
   end

   // Saturating underrun event counter.
   always_comb begin
      ucnt_d = ucnt_q;
      if (underrun && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
   end

   // State, divider, DAC and counter registers.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         dac_q   <= '0;
         ucnt_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         dac_q   <= dac_d;
         ucnt_q  <= ucnt_d;
      end
   end

   assign dac_data0_i  = dac_q.ch0.i;
   assign dac_data0_q  = dac_q.ch0.q;
   assign dac_data1_i  = dac_q.ch1.i;
   assign dac_data1_q  = dac_q.ch1.q;
   assign underrun_cnt = ucnt_q;

endmodule

// File: doc/ad9361_tx_feeder.md
Name: ad9361_tx_feeder

Overview:
Upstream neighbour of ad9361_if. Accepts 2-channel 12-bit I/Q sample beats over a valid/ready stream and buffers them in a small FIFO. Releases one beat per sample strobe onto the DAC data ports of ad9361_if (dac_data0_i/q, dac_data1_i/q); one instance per AD9361. Handles priming, underrun detection and flush on disable.

Parameters:
DEPTH, 16, FIFO depth in beats; power of 2, >= 4.
RATE_DIV, 4, sys_clk cycles per sample strobe; >= 2.
PRIME_LEVEL, 8, FIFO level required before output starts or restarts; 1..DEPTH.

Ports:
sys_clk  in  1  system clock; only clock.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  1 = stream to DAC; 0 = idle, flush FIFO.
s_valid  in  1  input beat valid.
s_ready  out  1  input beat accepted when s_valid & s_ready.
s_data  in  48  [11:0] ch0 I, [23:12] ch0 Q, [35:24] ch1 I, [47:36] ch1 Q.
dac_data0_i, dac_data0_q, dac_data1_i, dac_data1_q  out  12 each  registered DAC samples to ad9361_if.
sample_strobe  out  1  one-cycle pulse per sample period.
running  out  1  high in RUN state.
underrun_cnt  out  16  saturating underrun event count.
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0, async): state IDLE, all DAC outputs 0, sample_strobe 0, running 0, underrun_cnt 0, FIFO empty, strobe divider 0.
- Divider: counts 0..RATE_DIV-1 while enable=1; sample_strobe=1 in the cycle it equals RATE_DIV-1, then wraps to 0. Held at 0 while enable=0.
- FIFO: s_ready = !full && !flush. A write and a pop in the same cycle leave the level unchanged. Write is never accepted into a full FIFO, even on a pop cycle.
- flush = (state != IDLE) && enable==0. In that cycle: pointers reset, level -> 0, s_ready=0, state -> IDLE. DAC outputs are 0 from the next cycle.
- States:
  - IDLE: writes allowed; outputs 0. enable=1 -> PRIME.
  - PRIME: writes allowed; outputs 0. fifo_level >= PRIME_LEVEL -> RUN.
  - RUN: on sample_strobe, if not empty, pop head; DAC outputs update the next cycle (latency 1 from strobe) and hold until the next pop. If empty at strobe: outputs -> 0, underrun_cnt +1 (saturate at 0xFFFF), -> UNDERRUN.
  - UNDERRUN: outputs 0; writes allowed. fifo_level >= PRIME_LEVEL -> RUN; the first pop occurs at the next strobe after entry.
- enable=0 takes priority over all other transitions.
- running = (state == RUN).
- No arithmetic on sample data; bit slices map straight through.

Optional Feature:
TXFEED_TESTPAT_EN
- Defined: extra input port test_mode (1 bit). In RUN with test_mode=1, no FIFO pop occurs. On each strobe, 12-bit ramp cnt increments (wraps 0xFFF -> 0x000; reset 0). Outputs: data0_i = data1_i = cnt, data0_q = data1_q = ~cnt. No underrun detection while test_mode=1.
- Undefined: port absent; FIFO data path only.

Decomposition:
- Package ad9361_tx_pkg:
  - iq_sample_t: packed struct {q[11:0], i[11:0]}.
  - tx_beat_t: packed struct {ch1, ch0} of iq_sample_t, matching the s_data layout.
  - txfeed_state_e enum: IDLE, PRIME, RUN, UNDERRUN.
  - SAMPLE_W = 12.
- Sub-module txfeed_fifo: synchronous FIFO of tx_beat_t, DEPTH entries. Ports: wr_en, rd_en, flush, full, empty, level.
- FSM, divider and output registers live in the top level.

Test Plan:
1. Reset with rst_n=0 mid-RUN -> all outputs 0 immediately (async); after release, state IDLE and underrun_cnt=0.
2. enable=1, push 8 beats, ch0 I = 0x001..0x008, other fields 0x555 -> running rises once level=8. Each strobe (every 4 cycles) presents 0x001, 0x002, … on dac_data0_i one cycle after the strobe; dac_data0_q = 0x555.
3. Stop pushing after 8 beats in RUN -> after the 8th pop, the next strobe zeroes the outputs, underrun_cnt=1, running=0. Push 8 more -> running=1 again; data resumes at the next strobe.
4. Hold s_valid=1 continuously with enable=0 -> s_ready drops after 16 writes (fifo_level=16). Raise enable -> one pop per strobe; s_ready pulses high exactly once per pop.
5. Drop enable in RUN with level=5 -> one cycle later fifo_level=0, outputs 0, state IDLE; the beat offered in the flush cycle is not accepted.
6. (TXFEED_TESTPAT_EN) RUN, test_mode=1 -> per strobe, data0_i = 0x000, 0x001, …; data0_q = 0xFFF, 0xFFE, …; wraps after 0xFFF; fifo_level unchanged.
